// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester byte streams and UART byte interface shared by the arbiter
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ-1:0]   grant;
  logic [7:0]         tx_wdata;
  logic               tx_run_req;
  logic               tx_end_flag;
  logic               busy;
  logic               timeout_err;
  logic               err_clr;
  modport slave (
    input  req_valid, req_data, req_last, tx_end_flag, err_clr,
    output req_ready, grant, tx_wdata, tx_run_req, busy, timeout_err
  );
  modport master (
    output req_valid, req_data, req_last, tx_end_flag, err_clr,
    input  req_ready, grant, tx_wdata, tx_run_req, busy, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-level round-robin arbiter sharing one UART transmit path
module uart_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 20000
) (
  input logic              clk,
  input logic              rst_n,
  uart_tx_arbiter_if.slave bus
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;
  state_t state, state_n;
  logic [IW-1:0] rr_ptr, owner, pick;
  logic [CW-1:0] cnt;
  logic found, last_q, end_m, end_s, end_d, end_rise, hs, timeout;
  assign end_rise = end_s & ~end_d;
  assign hs       = (state == LOAD) & bus.req_valid[owner];
  assign timeout  = (state != IDLE) & (cnt == CW'(TIMEOUT_CYC));
  assign bus.grant      = (state == IDLE) ? '0 : N_REQ'(1) << owner;
  assign bus.req_ready  = (state == LOAD) ? bus.grant : '0;
  assign bus.tx_run_req = (state == SEND);
  assign bus.busy       = (state != IDLE);
  // round-robin scan upward from rr_ptr+1; the lowest offset wins
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (bus.req_valid[(int'(rr_ptr) + k) % N_REQ]) begin
        pick  = IW'((int'(rr_ptr) + k) % N_REQ);
        found = 1'b1;
      end
    end
  end
  // next state; the watchdog abort overrides every other transition
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = found ? LOAD : IDLE;
      LOAD:    state_n = hs ? SEND : LOAD;
      SEND:    state_n = end_rise ? DONE : SEND;
      DONE:    state_n = end_s ? DONE : (last_q ? IDLE : LOAD);
      default: state_n = IDLE;
    endcase
    if (timeout) state_n = IDLE;
  end
  // state, packet ownership, byte latch, watchdog and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner       <= '0;
      rr_ptr      <= IW'(N_REQ - 1);
      cnt         <= '0;
      last_q      <= 1'b0;
      bus.tx_wdata    <= 8'h00;
      bus.timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      owner       <= (state == IDLE && found) ? pick : owner;
      rr_ptr      <= (state != IDLE && state_n == IDLE) ? owner : rr_ptr;
      cnt         <= (state == IDLE || state_n != state) ? '0 : cnt + 1'b1;
      last_q      <= hs ? bus.req_last[owner] : last_q;
      bus.tx_wdata    <= hs ? bus.req_data[{owner, 3'b000} +: 8] : bus.tx_wdata;
      bus.timeout_err <= timeout | (bus.timeout_err & ~bus.err_clr);
    end
  end
  // two-flop synchronizer for the divided-clock done flag plus edge history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      end_m <= 1'b0;
      end_s <= 1'b0;
      end_d <= 1'b0;
    end else begin
      end_m <= bus.tx_end_flag;
      end_s <= end_m;
      end_d <= end_s;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
  localparam int N        = 4;
  localparam int TO_MAIN  = 1000;
  localparam int TO_SHORT = 100;
  localparam int D        = 200;
  logic clk = 0, uclk = 0, rst_n = 0;
  always #5 clk = ~clk;
  always #37 uclk = ~uclk;
  uart_tx_arbiter_if #(.N_REQ(N)) bus ();
  uart_tx_arbiter_if #(.N_REQ(N)) bus2 ();
  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TO_MAIN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TO_SHORT)) dut_to (.clk(clk), .rst_n(rst_n), .bus(bus2));
  int checks = 0, errors = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // transmitter model: end_flag D cycles after run_req, cleared 2 cycles after run_req falls
  logic s_end = 0;
  int rc = 0, fc = 0;
  always @(posedge clk) begin
    if (bus.tx_run_req) begin
      fc <= 0;
      if (rc < D) rc <= rc + 1;
      else s_end <= 1;
    end else begin
      rc <= 0;
      if (s_end) begin
        if (fc == 1) s_end <= 0;
        fc <= fc + 1;
      end else fc <= 0;
    end
  end
  // transmitter model on an unrelated clock
  logic use_async = 0, a_end = 0;
  int a_cnt = 0, a_pulses = 0;
  always @(posedge uclk) begin
    if (!use_async || !bus.tx_run_req) begin
      a_end <= 0;
      a_cnt <= 0;
    end else if (a_cnt < 6) a_cnt <= a_cnt + 1;
    else if (!a_end) begin
      a_end    <= 1;
      a_pulses <= a_pulses + 1;
    end
  end
  assign bus.tx_end_flag  = use_async ? a_end : s_end;
  assign bus2.tx_end_flag = 1'b0;
  // requesters: per-requester byte queues {last, data}; monitors sampled mid-cycle
  logic [8:0] rq [N][$];
  logic [N-1:0] hold = '0, pend = '0;
  logic [7:0] tx_log [$];
  logic [3:0] gnt_log [$];
  int gap_log [$];
  int acc_cnt [N];
  int idle_run = 0, stab_err = 0, r0_err = 0;
  logic prev_run = 0;
  logic [7:0] prev_wd = 0;
  logic [3:0] prev_g = 0;
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (pend[i] && rq[i].size() > 0) begin
        void'(rq[i].pop_front());
        acc_cnt[i]++;
      end
      bus.req_valid[i]       = rq[i].size() > 0 && !hold[i];
      bus.req_last[i]        = rq[i].size() > 0 ? rq[i][0][8] : 1'b0;
      bus.req_data[8*i +: 8] = rq[i].size() > 0 ? rq[i][0][7:0] : 8'h00;
      pend[i] = bus.req_valid[i] && bus.req_ready[i];
    end
    if (bus.tx_run_req && !prev_run) tx_log.push_back(bus.tx_wdata);
    if (bus.tx_run_req && prev_run && bus.tx_wdata != prev_wd) stab_err++;
    if (bus.grant != 0 && bus.grant != prev_g) begin
      gnt_log.push_back(bus.grant);
      gap_log.push_back(idle_run);
    end
    idle_run = (bus.grant == 0) ? idle_run + 1 : 0;
    if (bus.grant == 4'b0100 && bus.req_ready[0]) r0_err++;
    prev_run = bus.tx_run_req;
    prev_wd  = bus.tx_wdata;
    prev_g   = bus.grant;
  end
  function automatic bit queued();
    for (int i = 0; i < N; i++) if (rq[i].size() > 0) return 1;
    return 0;
  endfunction
  task automatic clear_logs();
    tx_log.delete();
    gnt_log.delete();
    gap_log.delete();
    for (int i = 0; i < N; i++) acc_cnt[i] = 0;
  endtask
  task automatic wait_idle(input string tag, input int lim);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((bus.busy || queued()) && n < lim);
    chk(tag, n < lim, 1);
  endtask
  initial begin
    int n;
    bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0; bus.err_clr = 0;
    bus2.req_valid = '0; bus2.req_data = '0; bus2.req_last = '0; bus2.err_clr = 0;
    for (int i = 0; i < N; i++) acc_cnt[i] = 0;
    #12;
    chk("rst_run", bus.tx_run_req, 0);
    chk("rst_wdata", bus.tx_wdata, 8'h00);
    chk("rst_grant", bus.grant, 0);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_err", bus.timeout_err, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    // single requester 1, three-byte packet
    @(posedge clk); #1;
    rq[1].push_back({1'b0, 8'h41});
    rq[1].push_back({1'b0, 8'h42});
    rq[1].push_back({1'b1, 8'h43});
    @(negedge clk);
    chk("lat_idle_grant", bus.grant, 0);
    @(negedge clk);
    chk("lat_load_grant", bus.grant, 4'b0010);
    chk("lat_load_ready", bus.req_ready, 4'b0010);
    chk("lat_load_run", bus.tx_run_req, 0);
    @(negedge clk);
    chk("lat_send_run", bus.tx_run_req, 1);
    chk("lat_send_wdata", bus.tx_wdata, 8'h41);
    wait_idle("t1_done", 3000);
    chk("t1_nbytes", tx_log.size(), 3);
    for (int i = 0; i < 3 && i < tx_log.size(); i++) chk("t1_byte", tx_log[i], 8'h41 + i);
    chk("t1_ngrant", gnt_log.size(), 1);
    if (gnt_log.size() > 0) chk("t1_grant", gnt_log[0], 4'b0010);
    chk("t1_acc", acc_cnt[1], 3);
    chk("t1_end_grant", bus.grant, 0);
    chk("t1_end_busy", bus.busy, 0);
    // reset while run_req is high
    rq[3].push_back({1'b0, 8'h71});
    rq[3].push_back({1'b1, 8'h72});
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.tx_run_req && n < 50);
    chk("t5_run_seen", bus.tx_run_req, 1);
    #2 rst_n = 0;
    #1;
    chk("t5_run", bus.tx_run_req, 0);
    chk("t5_grant", bus.grant, 0);
    chk("t5_ready", bus.req_ready, 0);
    chk("t5_busy", bus.busy, 0);
    chk("t5_wdata", bus.tx_wdata, 8'h00);
    for (int i = 0; i < N; i++) rq[i].delete();
    pend = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    // all four requesters valid at once, 1-byte packets
    @(posedge clk); #1;
    clear_logs();
    rq[0].push_back({1'b1, 8'hA0});
    rq[0].push_back({1'b1, 8'hA4});
    rq[1].push_back({1'b1, 8'hA1});
    rq[2].push_back({1'b1, 8'hA2});
    rq[3].push_back({1'b1, 8'hA3});
    wait_idle("t2_done", 5000);
    chk("t2_ngrant", gnt_log.size(), 5);
    for (int i = 0; i < 5 && i < gnt_log.size(); i++) chk("t2_grant", gnt_log[i], 4'b0001 << (i % 4));
    for (int i = 1; i < 5 && i < gap_log.size(); i++) chk("t2_gap", gap_log[i], 1);
    for (int i = 0; i < 5 && i < tx_log.size(); i++) chk("t2_byte", tx_log[i], 8'hA0 + i);
    // requester 2 stalls mid-packet while requester 0 waits
    @(posedge clk); #1;
    clear_logs();
    r0_err = 0;
    rq[2].push_back({1'b0, 8'hC1});
    rq[2].push_back({1'b0, 8'hC2});
    rq[2].push_back({1'b1, 8'hC3});
    n = 0;
    do begin @(negedge clk); n++; end while (acc_cnt[2] == 0 && n < 50);
    hold[2] = 1;
    rq[0].push_back({1'b1, 8'hC0});
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.req_ready[2] && n < 1000);
    chk("t3_in_load", bus.req_ready[2], 1);
    repeat (50) @(negedge clk);
    chk("t3_hold_grant", bus.grant, 4'b0100);
    chk("t3_hold_ready0", bus.req_ready[0], 0);
    hold[2] = 0;
    wait_idle("t3_done", 3000);
    chk("t3_ngrant", gnt_log.size(), 2);
    if (gnt_log.size() == 2) begin
      chk("t3_grant0", gnt_log[0], 4'b0100);
      chk("t3_grant1", gnt_log[1], 4'b0001);
    end
    chk("t3_r0_err", r0_err, 0);
    chk("t3_nbytes", tx_log.size(), 4);
    if (tx_log.size() == 4) begin
      chk("t3_b0", tx_log[0], 8'hC1);
      chk("t3_b2", tx_log[2], 8'hC3);
      chk("t3_b3", tx_log[3], 8'hC0);
    end
    // end_flag from an unrelated clock: one byte per pulse
    @(posedge clk); #1;
    clear_logs();
    a_pulses = 0;
    use_async = 1;
    rq[3].push_back({1'b0, 8'hD1});
    rq[3].push_back({1'b0, 8'hD2});
    rq[3].push_back({1'b1, 8'hD3});
    wait_idle("t6_done", 3000);
    chk("t6_pulses", a_pulses, 3);
    chk("t6_acc", acc_cnt[3], 3);
    chk("t6_nbytes", tx_log.size(), 3);
    for (int i = 0; i < 3 && i < tx_log.size(); i++) chk("t6_byte", tx_log[i], 8'hD1 + i);
    use_async = 0;
    chk("wdata_stable", stab_err, 0);
    // watchdog abort on a transmitter that never answers
    @(posedge clk); #1;
    bus2.req_valid = 4'b0010;
    bus2.req_data  = 32'h0000_5500;
    bus2.req_last  = 4'b0010;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!bus2.req_ready[1] && n < 20);
    @(posedge clk); #1;
    bus2.req_valid = '0;
    chk("t4_run_start", bus2.tx_run_req, 1);
    chk("t4_wdata", bus2.tx_wdata, 8'h55);
    n = 0;
    while (bus2.tx_run_req && n < 500) begin @(posedge clk); #1; n++; end
    chk("t4_run_len", n >= TO_SHORT && n <= TO_SHORT + 1, 1);
    chk("t4_err", bus2.timeout_err, 1);
    chk("t4_grant", bus2.grant, 0);
    chk("t4_busy", bus2.busy, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("t4_sticky", bus2.timeout_err, 1);
    bus2.err_clr = 1;
    @(posedge clk); #1;
    bus2.err_clr = 0;
    chk("t4_cleared", bus2.timeout_err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
